// File: rtl/fir_filt_mc_if.sv
// fir_filt_mc_if: sample, coefficient and shift ports of fir_filt_mc.
// sat_flag is present only when FIR_SAT_EN is defined.
interface fir_filt_mc_if #(
    parameter int SIG_W  = 12,
    parameter int COEF_W = 18,
    parameter int NTAPS  = 16,
    parameter int NCH    = 2,
    parameter int MAX_SH = 32
);
    localparam int AW   = $clog2(NTAPS);
    localparam int SH_W = $clog2(MAX_SH);

    logic                   flush;
    logic [AW-1:0]          coef_addr;
    logic [COEF_W-1:0]      coef_wdata;
    logic                   coef_we;
    logic                   coef_ack;
    logic [COEF_W-1:0]      coef_rdata;
    logic [SH_W-1:0]        shift_i;
    logic                   shift_we;
    logic [SH_W-1:0]        shift_q;
    logic                   in_valid;
    logic [NCH*SIG_W-1:0]   in_data;
    logic                   out_valid;
    logic [NCH*SIG_W-1:0]   out_data;
    logic                   busy;
    logic                   overrun;
`ifdef FIR_SAT_EN
    logic                   sat_flag;
`endif

    modport slave (
        input  flush, coef_addr, coef_wdata, coef_we,
        input  shift_i, shift_we, in_valid, in_data,
        output coef_ack, coef_rdata, shift_q,
        output out_valid, out_data, busy, overrun
`ifdef FIR_SAT_EN
        , output sat_flag
`endif
    );

    modport master (
        output flush, coef_addr, coef_wdata, coef_we,
        output shift_i, shift_we, in_valid, in_data,
        input  coef_ack, coef_rdata, shift_q,
        input  out_valid, out_data, busy, overrun
`ifdef FIR_SAT_EN
        , input sat_flag
`endif
    );
endinterface

// File: rtl/fir_filt_mc.sv
// fir_filt_mc: multi-channel decimating FIR on one shared multiplier.
// FIR_SAT_EN selects saturating outputs plus sat_flag; default wraps.
module fir_filt_mc #(
    parameter int SIG_W  = 12,
    parameter int COEF_W = 18,
    parameter int NTAPS  = 16,
    parameter int NCH    = 2,
    parameter int ACC_W  = 40,
    parameter int DECIM  = 1,
    parameter int MAX_SH = 32
) (
    input  logic          clk,
    input  logic          rst,
    fir_filt_mc_if.slave  bus
);
    localparam int AW   = $clog2(NTAPS);
    localparam int SH_W = $clog2(MAX_SH);
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int DW   = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int PW   = SIG_W + COEF_W;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DRAIN, S_OUT} state_t;
    state_t r_state, w_nstate;

    logic signed [COEF_W-1:0] r_coef [NTAPS];
    logic signed [SIG_W-1:0]  r_dl   [NCH][NTAPS];
    logic signed [ACC_W-1:0]  r_acc  [NCH];
    logic signed [PW-1:0]     r_prod;
    logic [CW-1:0]            r_ch, r_pch;
    logic [AW-1:0]            r_tap;
    logic                     r_pvld, r_pfirst, r_drn;
    logic [DW-1:0]            r_dcnt;
    logic [SH_W-1:0]          r_sh;
    logic [COEF_W-1:0]        r_rdata;
    logic                     r_ack, r_ovr, r_ovld;
    logic [NCH*SIG_W-1:0]     r_out;

    logic                     w_take, w_drop, w_cwr, w_swr, w_mac_last;
    logic signed [PW-1:0]     w_prod;
    logic signed [ACC_W-1:0]  w_pext, w_half;
    logic signed [ACC_W-1:0]  w_sum [NCH];
    logic [NCH*SIG_W-1:0]     w_out;
`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SMAX =
        {{(ACC_W-SIG_W+1){1'b0}}, {(SIG_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SMIN =
        {{(ACC_W-SIG_W+1){1'b1}}, {(SIG_W-1){1'b0}}};
    logic signed [ACC_W-1:0]  w_r [NCH];
    logic [NCH-1:0]           w_clip;
    logic                     r_sat;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_nstate;
    end

    always_comb begin
        w_nstate   = r_state;
        w_take     = 1'b0;
        w_drop     = 1'b0;
        w_cwr      = 1'b0;
        w_swr      = 1'b0;
        w_mac_last = (r_ch == CW'(NCH-1)) && (r_tap == AW'(NTAPS-1));
        unique case (r_state)
            S_IDLE: begin
                w_take = bus.in_valid;
                w_cwr  = bus.coef_we && !bus.in_valid && !r_ack;
                w_swr  = bus.shift_we;
                if (bus.in_valid && r_dcnt == DW'(DECIM-1))
                    w_nstate = S_MAC;
            end
            S_MAC: begin
                w_drop = bus.in_valid;
                if (w_mac_last) w_nstate = S_DRAIN;
            end
            S_DRAIN: begin
                w_drop = bus.in_valid;
                if (r_drn) w_nstate = S_OUT;
            end
            S_OUT: begin
                w_drop   = bus.in_valid;
                w_nstate = S_IDLE;
            end
            default: w_nstate = S_IDLE;
        endcase
        if (bus.flush) begin
            w_nstate = S_IDLE;
            w_take   = 1'b0;
            w_drop   = 1'b0;
            w_cwr    = 1'b0;
            w_swr    = 1'b0;
        end
    end

    assign w_prod = PW'(r_dl[r_ch][r_tap]) * PW'(r_coef[r_tap]);
    assign w_pext = ACC_W'(r_prod);
    assign w_half = (r_sh == '0) ? '0 : (ACC_W'(1) <<< (r_sh - 1'b1));

    // Round half up, then narrow each channel to SIG_W.
    always_comb begin
        w_out = '0;
`ifdef FIR_SAT_EN
        w_clip = '0;
`endif
        for (int c = 0; c < NCH; c++) begin
            w_sum[c] = r_acc[c] + w_half;
`ifdef FIR_SAT_EN
            w_r[c] = w_sum[c] >>> r_sh;
            if (w_r[c] > SMAX) begin
                w_out[c*SIG_W +: SIG_W] = SMAX[SIG_W-1:0];
                w_clip[c] = 1'b1;
            end else if (w_r[c] < SMIN) begin
                w_out[c*SIG_W +: SIG_W] = SMIN[SIG_W-1:0];
                w_clip[c] = 1'b1;
            end else begin
                w_out[c*SIG_W +: SIG_W] = w_r[c][SIG_W-1:0];
            end
`else
            w_out[c*SIG_W +: SIG_W] = SIG_W'(w_sum[c] >>> r_sh);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_ch     <= '0;
            r_tap    <= '0;
            r_pch    <= '0;
            r_prod   <= '0;
            r_pvld   <= 1'b0;
            r_pfirst <= 1'b0;
            r_drn    <= 1'b0;
            r_dcnt   <= '0;
            r_ovr    <= 1'b0;
            r_ovld   <= 1'b0;
            r_out    <= '0;
`ifdef FIR_SAT_EN
            r_sat    <= 1'b0;
`endif
            for (int c = 0; c < NCH; c++) begin
                r_acc[c] <= '0;
                for (int t = 0; t < NTAPS; t++) r_dl[c][t] <= '0;
            end
        end else begin
            r_pvld <= 1'b0;
            r_ovld <= 1'b0;
`ifdef FIR_SAT_EN
            r_sat  <= 1'b0;
`endif
            if (w_take) begin
                for (int c = 0; c < NCH; c++) begin
                    r_dl[c][0] <= bus.in_data[c*SIG_W +: SIG_W];
                    for (int t = 1; t < NTAPS; t++)
                        r_dl[c][t] <= r_dl[c][t-1];
                end
                r_dcnt <= (r_dcnt == DW'(DECIM-1)) ? '0 : r_dcnt + 1'b1;
            end
            if (w_drop) r_ovr <= 1'b1;
            if (r_state == S_MAC) begin
                r_prod   <= w_prod;
                r_pvld   <= 1'b1;
                r_pch    <= r_ch;
                r_pfirst <= (r_tap == '0);
                if (r_tap == AW'(NTAPS-1)) begin
                    r_tap <= '0;
                    r_ch  <= (r_ch == CW'(NCH-1)) ? '0 : r_ch + 1'b1;
                end else begin
                    r_tap <= r_tap + 1'b1;
                end
            end
            r_drn <= (r_state == S_DRAIN) && !r_drn;
            // First tap of a channel restarts its accumulator.
            if (r_pvld)
                r_acc[r_pch] <= r_pfirst ? w_pext : r_acc[r_pch] + w_pext;
            if (r_state == S_OUT) begin
                r_out  <= w_out;
                r_ovld <= 1'b1;
`ifdef FIR_SAT_EN
                r_sat  <= |w_clip;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < NTAPS; t++)
                r_coef[t] <= (t == 0) ? COEF_W'(1) : '0;
            r_sh    <= '0;
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack   <= w_cwr;
            if (w_cwr) r_coef[bus.coef_addr] <= bus.coef_wdata;
            if (w_swr) r_sh <= bus.shift_i;
            r_rdata <= r_coef[bus.coef_addr];
        end
    end

    assign bus.coef_ack   = r_ack;
    assign bus.coef_rdata = r_rdata;
    assign bus.shift_q    = r_sh;
    assign bus.out_valid  = r_ovld;
    assign bus.out_data   = r_out;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.overrun    = r_ovr;
`ifdef FIR_SAT_EN
    assign bus.sat_flag   = r_sat;
`endif
endmodule
